// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// Frame state encoding and parity selection values.
package uart_rx_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and bit counter for the UART receiver.
// Both counters are held at zero while disabled.
module uart_rx_edge_bit_counter #(
    parameter int PRESCALE_W = 8,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [PRESCALE_W-1:0] Edge_Cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  bit_end
);

    assign bit_end = enable && (Edge_Cnt == Prescale - 1'b1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Edge_Cnt <= '0;
            bit_cnt  <= '0;
        end else if (!enable) begin
            Edge_Cnt <= '0;
            bit_cnt  <= '0;
        end else if (bit_end) begin
            Edge_Cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
        end else begin
            Edge_Cnt <= Edge_Cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detect, deserialise, parity/stop check.
// Drives the bit sampler timing and consumes its voted bit.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PRESCALE_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  Sampled_Bit,
    output logic                  Sample_En,
    output logic [PRESCALE_W-1:0] Edge_Cnt,
    output logic                  Busy,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stop_Err
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 4);

    rx_state_t             state;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bad;
    logic                  active;
    logic                  bit_end;
    logic                  exp_par;
    logic [BIT_CNT_W-1:0]  bit_cnt;

    assign active    = (state != IDLE);
    assign Busy      = active;
    assign Sample_En = active;
    assign exp_par   = (par_typ_q == PAR_ODD) ? ~^shift : ^shift;

    uart_rx_edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .enable   (active),
        .Prescale (Prescale),
        .Edge_Cnt (Edge_Cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            shift      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad    <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        state     <= START;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_bad   <= 1'b0;
                    end
                end
                START: begin
                    // A start bit that votes high was a line glitch
                    if (bit_end) begin
                        state <= Sampled_Bit ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift <= {Sampled_Bit, shift[DATA_WIDTH-1:1]};
                        if (bit_cnt == BIT_CNT_W'(DATA_WIDTH)) begin
                            state <= par_en_q ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        par_bad <= (Sampled_Bit != exp_par);
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state      <= IDLE;
                        Stop_Err   <= ~Sampled_Bit;
                        Par_Err    <= par_bad;
                        Data_Valid <= Sampled_Bit & ~par_bad;
                        if (Sampled_Bit && !par_bad) begin
                            P_DATA <= shift;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: frame-level model with per-cycle compare.
// Includes a simple mid-bit sampler standing in for the majority voter.
module tb_uart_rx_frame_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [7:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       Sampled_Bit;
    logic       Sample_En;
    logic [7:0] Edge_Cnt;
    logic       Busy;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stop_Err;

    uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .Sampled_Bit (Sampled_Bit),
        .Sample_En   (Sample_En),
        .Edge_Cnt    (Edge_Cnt),
        .Busy        (Busy),
        .P_DATA      (P_DATA),
        .Data_Valid  (Data_Valid),
        .Par_Err     (Par_Err),
        .Stop_Err    (Stop_Err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         t0;
        int         len;
        int         p;
        bit         gl;
        bit         pe;
        bit         se;
        logic [7:0] data;
    } frame_t;

    frame_t     q[$];
    int         cyc = 0;
    int         last_idle = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_pd = 8'h00;

    int         dv_cyc[$];
    logic [7:0] dv_dat[$];
    int         n_pe = 0;
    int         n_se = 0;
    int         last_pe_cyc = -1;
    int         last_se_cyc = -1;
    int         busy_run = 0;
    int         last_busy_run = 0;

    always @(posedge CLK) cyc++;

    // Sampler stand-in: latch the line at the mid-bit edge index
    always @(negedge CLK) begin
        if (Sample_En && Edge_Cnt == (Prescale >> 1) + 8'd1)
            Sampled_Bit = RX_IN;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d",
                     nm, cyc, act, exp);
        end
    endtask

    // Start is seen on the edge after the line drops, but never
    // before the cycle following the previous frame's end.
    function automatic int model_push(input int c, input int len,
                                      input int p, input bit gl,
                                      input bit pe, input bit se,
                                      input logic [7:0] d);
        frame_t f;
        f.t0   = (c + 1 > last_idle) ? c + 1 : last_idle;
        f.len  = len;
        f.p    = p;
        f.gl   = gl;
        f.pe   = pe;
        f.se   = se;
        f.data = d;
        q.push_back(f);
        last_idle = f.t0 + len + 1;
        return f.t0;
    endfunction

    always @(negedge CLK) begin
        int         e_ec;
        bit         e_busy, e_dv, e_pe, e_se;
        if (!RST) begin
            q.delete();
            last_idle = 0;
            exp_pd    = 8'h00;
            e_busy = 0; e_ec = 0; e_dv = 0; e_pe = 0; e_se = 0;
        end else begin
            e_busy = 0; e_ec = 0; e_dv = 0; e_pe = 0; e_se = 0;
            foreach (q[i]) begin
                if (cyc >= q[i].t0 && cyc < q[i].t0 + q[i].len) begin
                    e_busy = 1;
                    e_ec   = (cyc - q[i].t0) % q[i].p;
                end
                if (cyc == q[i].t0 + q[i].len && !q[i].gl) begin
                    e_pe = q[i].pe;
                    e_se = q[i].se;
                    e_dv = !q[i].pe && !q[i].se;
                    if (e_dv) exp_pd = q[i].data;
                end
            end
            while (q.size() > 0 && cyc >= q[0].t0 + q[0].len)
                void'(q.pop_front());
        end
        chk("busy", int'(Busy), int'(e_busy));
        chk("sample_en", int'(Sample_En), int'(e_busy));
        chk("edge_cnt", int'(Edge_Cnt), e_ec);
        chk("data_valid", int'(Data_Valid), int'(e_dv));
        chk("par_err", int'(Par_Err), int'(e_pe));
        chk("stop_err", int'(Stop_Err), int'(e_se));
        chk("p_data", int'(P_DATA), int'(exp_pd));

        if (Data_Valid) begin
            dv_cyc.push_back(cyc);
            dv_dat.push_back(P_DATA);
        end
        if (Par_Err) begin n_pe++; last_pe_cyc = cyc; end
        if (Stop_Err) begin n_se++; last_se_cyc = cyc; end
        if (Busy) busy_run++;
        else if (busy_run > 0) begin
            last_busy_run = busy_run;
            busy_run = 0;
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic pen,
                              input logic ptyp, input logic flip,
                              input logic stop_b, input int p,
                              output int t0_o);
        logic [10:0] bits;
        int          nb;
        Prescale = 8'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        nb       = 10 + int'(pen);
        t0_o = model_push(cyc, nb * p, p, 1'b0, pen & flip, ~stop_b, d);
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        if (pen) bits[9] = (ptyp ? ~^d : ^d) ^ flip;
        bits[nb - 1] = stop_b;
        for (int i = 0; i < nb; i++) begin
            RX_IN = bits[i];
            repeat (p) @(posedge CLK);
            #1;
        end
        RX_IN = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        int t0, t0b, dummy;
        RST         = 1'b0;
        RX_IN       = 1'b1;
        Sampled_Bit = 1'b1;
        Prescale    = 8'd8;
        PAR_EN      = 1'b0;
        PAR_TYP     = 1'b0;

        idle(3);
        chk("rst_p_data", int'(P_DATA), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_edge_cnt", int'(Edge_Cnt), 0);
        RST = 1'b1;
        idle(2);

        // Good even-parity frame
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8, t0);
        idle(4);
        chk("a5_dv_count", dv_cyc.size(), 1);
        chk("a5_latency", dv_cyc[0] - t0, 88);
        chk("a5_p_data", int'(P_DATA), 8'hA5);

        // Wrong parity bit
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8, t0);
        idle(4);
        chk("perr_latency", last_pe_cyc - t0, 88);
        chk("perr_dv_count", dv_cyc.size(), 1);
        chk("perr_p_data", int'(P_DATA), 8'hA5);

        // Stop bit low, no parity
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 16, t0);
        idle(4);
        chk("serr_latency", last_se_cyc - t0, 160);
        chk("serr_count", n_se, 1);
        chk("serr_p_data", int'(P_DATA), 8'hA5);

        // Start glitch
        Prescale = 8'd8;
        RX_IN = 1'b0;
        dummy = model_push(cyc, 8, 8, 1'b1, 1'b0, 1'b0, 8'h00);
        idle(3);
        RX_IN = 1'b1;
        idle(12);
        chk("glitch_busy_len", last_busy_run, 8);
        chk("glitch_dv_count", dv_cyc.size(), 1);
        chk("glitch_pe_count", n_pe, 1);

        // Back-to-back odd-parity frames
        send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 16, t0);
        send_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 16, t0b);
        idle(4);
        chk("b2b_dv_count", dv_cyc.size(), 3);
        chk("b2b_data0", int'(dv_dat[1]), 8'hC3);
        chk("b2b_data1", int'(dv_dat[2]), 8'h81);
        chk("b2b_spacing", dv_cyc[2] - dv_cyc[1], 177);
        chk("b2b_lat1", dv_cyc[2] - t0b, 176);

        // Reset in the middle of a frame
        Prescale = 8'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        dummy = model_push(cyc, 80, 8, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(8);
        RX_IN = 1'b1;
        repeat (20) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("arst_busy", int'(Busy), 0);
        chk("arst_sample_en", int'(Sample_En), 0);
        chk("arst_edge_cnt", int'(Edge_Cnt), 0);
        chk("arst_p_data", int'(P_DATA), 0);
        idle(2);
        RST = 1'b1;
        idle(3);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8, t0);
        idle(4);
        chk("post_rst_dv_count", dv_cyc.size(), 4);
        chk("post_rst_latency", dv_cyc[3] - t0, 80);
        chk("post_rst_p_data", int'(P_DATA), 8'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
